// File: rtl/mi_arb_pkg.sv
// Shared encodings for the PSRAM memory-interface arbiter.
package mi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating find-first-set: returns a one-hot grant for the first request
// found at or above index ptr_i, wrapping modulo N.
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [PW:0] idx;
    logic        found;

    // Walking k from 0 visits indices in rotated order ptr, ptr+1, ...
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_i} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                gnt_o[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mi_arbiter.sv
// N-way arbiter for the QPI PSRAM memory interface; one transaction at a time.
// Define MI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mi_arbiter
    import mi_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int LW = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW*N-1:0] s_addr,
    input  logic [LW*N-1:0] s_len,
    input  logic [N-1:0]    s_rw,
    input  logic [N-1:0]    s_valid,
    output logic [N-1:0]    s_ready,
    input  logic [32*N-1:0] s_wdata,
    output logic [N-1:0]    s_wack,
    output logic [N-1:0]    s_wlast,
    output logic [31:0]     s_rdata,
    output logic [N-1:0]    s_rstb,
    output logic [N-1:0]    s_rlast,
    output logic [AW-1:0]   m_addr,
    output logic [LW-1:0]   m_len,
    output logic            m_rw,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [31:0]     m_wdata,
    input  logic            m_wack,
    input  logic            m_wlast,
    input  logic [31:0]     m_rdata,
    input  logic            m_rstb,
    input  logic            m_rlast,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int PW = ptr_width(N);

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    pick;
    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   ptr_after;
    logic            done;

    logic [AW-1:0]   addr_arr  [N];
    logic [LW-1:0]   len_arr   [N];
    logic [31:0]     wdata_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign addr_arr[gi]  = s_addr[gi*AW +: AW];
        assign len_arr[gi]   = s_len[gi*LW +: LW];
        assign wdata_arr[gi] = s_wdata[gi*32 +: 32];
    end

    arb_rr_pick #(.N(N), .PW(PW)) u_pick (
        .req_i (s_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) g_idx = PW'(i);
        end
    end

`ifdef MI_ARB_FIXED_PRIO_EN
    assign ptr_after = '0;
`else
    assign ptr_after = (g_idx == PW'(N-1)) ? '0 : g_idx + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        done    = 1'b0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_len   = '0;
        m_rw    = RW_WRITE;
        m_wdata = '0;
        s_ready = '0;
        s_wack  = '0;
        s_wlast = '0;
        s_rstb  = '0;
        s_rlast = '0;
        case (state_q)
            ST_IDLE: begin
                if (|s_valid) begin
                    grant_d = pick;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                m_valid = s_valid[g_idx];
                m_addr  = addr_arr[g_idx];
                m_len   = len_arr[g_idx];
                m_rw    = s_rw[g_idx];
                s_ready = grant_q & {N{m_ready}};
                // A requester withdrawing mid-command forfeits its turn without moving ptr.
                if (!s_valid[g_idx]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (m_ready) begin
                    state_d = (s_rw[g_idx] == RW_READ) ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                m_wdata = wdata_arr[g_idx];
                s_wack  = grant_q & {N{m_wack}};
                s_wlast = grant_q & {N{m_wlast}};
                done    = m_wack & m_wlast;
            end
            ST_RDATA: begin
                s_rstb  = grant_q & {N{m_rstb}};
                s_rlast = grant_q & {N{m_rlast}};
                done    = m_rstb & m_rlast;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        if (done) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = ptr_after;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign s_rdata = m_rdata;

endmodule

// File: tb/tb_mi_arbiter.sv
// Directed self-checking bench for mi_arbiter (N=2); honours MI_ARB_FIXED_PRIO_EN.
module tb_mi_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int LW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW*N-1:0] s_addr;
    logic [LW*N-1:0] s_len;
    logic [N-1:0]    s_rw, s_valid, s_ready;
    logic [32*N-1:0] s_wdata;
    logic [N-1:0]    s_wack, s_wlast, s_rstb, s_rlast;
    logic [31:0]     s_rdata;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic            m_rw, m_valid, m_ready;
    logic [31:0]     m_wdata, m_rdata;
    logic            m_wack, m_wlast, m_rstb, m_rlast;
    logic [N-1:0]    grant;
    logic            busy;

    int checks = 0;
    int errors = 0;

    mi_arbiter #(.N(N), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_addr(s_addr), .s_len(s_len), .s_rw(s_rw), .s_valid(s_valid),
        .s_ready(s_ready), .s_wdata(s_wdata), .s_wack(s_wack), .s_wlast(s_wlast),
        .s_rdata(s_rdata), .s_rstb(s_rstb), .s_rlast(s_rlast),
        .m_addr(m_addr), .m_len(m_len), .m_rw(m_rw), .m_valid(m_valid),
        .m_ready(m_ready), .m_wdata(m_wdata), .m_wack(m_wack), .m_wlast(m_wlast),
        .m_rdata(m_rdata), .m_rstb(m_rstb), .m_rlast(m_rlast),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        s_addr = '0; s_len = '0; s_rw = '0; s_valid = '0; s_wdata = '0;
        m_ready = 1'b0; m_wack = 1'b0; m_wlast = 1'b0;
        m_rdata = '0; m_rstb = 1'b0; m_rlast = 1'b0;
    endtask

    // Runs one single-beat write for whoever wins; returns the grant seen in CMD.
    task automatic do_txn(output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (grant != '0) break;
        end
        g = grant;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        if (g == 2'b10) s_valid[1] = 1'b0;
        m_wack = 1'b1; m_wlast = 1'b1;
        step();
        m_wack = 1'b0; m_wlast = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        checks++; if ({m_valid, m_addr, m_len, m_rw, m_wdata} !== '0) begin errors++; $display("FAIL reset_m got v=%b a=%h l=%h rw=%b wd=%h exp all 0", m_valid, m_addr, m_len, m_rw, m_wdata); end
        checks++; if ({s_ready, s_wack, s_wlast, s_rstb, s_rlast, grant, busy} !== '0) begin errors++; $display("FAIL reset_s got rdy=%b wack=%b wlast=%b rstb=%b rlast=%b grant=%b busy=%b exp all 0", s_ready, s_wack, s_wlast, s_rstb, s_rlast, grant, busy); end
        m_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (s_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_rdata_pass got %h exp deadbeef", s_rdata); end
        m_rdata = '0;
        step();
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        s_addr[31:0] = 32'h100; s_len[6:0] = 7'd3; s_rw = 2'b00; s_valid = 2'b01;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sw_idle_mvalid got %b exp 0", m_valid); end
        step();
        checks++; if ({m_valid, m_addr, m_len, m_rw, grant} !== {1'b1, 32'h100, 7'd3, 1'b0, 2'b01}) begin errors++; $display("FAIL sw_cmd got v=%b a=%h l=%0d rw=%b g=%b exp 1 100 3 0 01", m_valid, m_addr, m_len, m_rw, grant); end
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 2'b01) begin errors++; $display("FAIL sw_sready got %b exp 01", s_ready); end
        step();
        s_valid = 2'b00; m_ready = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sw_wdata_mvalid got %b exp 0", m_valid); end
        for (int b = 0; b < 4; b++) begin
            s_wdata[31:0] = 32'hA5A5_0000 + 32'(b);
            m_wack = 1'b1; m_wlast = (b == 3);
            #1;
            checks++; if ({s_wack, s_wlast, m_wdata} !== {2'b01, (b == 3) ? 2'b01 : 2'b00, 32'hA5A5_0000 + 32'(b)}) begin errors++; $display("FAIL sw_beat%0d got wack=%b wlast=%b wd=%h", b, s_wack, s_wlast, m_wdata); end
            step();
        end
        m_wack = 1'b0; m_wlast = 1'b0;
        #1;
        checks++; if ({busy, grant, s_wack} !== 5'b0) begin errors++; $display("FAIL sw_end got busy=%b grant=%b wack=%b exp 0", busy, grant, s_wack); end
        clear_inputs();
        $display("test_single_write done");
    endtask

    task automatic test_contention();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        s_addr = {32'h300, 32'h200}; s_len = {7'd2, 7'd1}; s_rw = 2'b11; s_valid = 2'b11;
        step();
        checks++; if ({grant, m_addr, m_rw} !== {2'b01, 32'h200, 1'b1}) begin errors++; $display("FAIL ct_first got g=%b a=%h rw=%b exp 01 200 1", grant, m_addr, m_rw); end
        m_ready = 1'b1; step();
        m_ready = 1'b0; s_valid = 2'b10;
        for (int b = 0; b < 2; b++) begin
            m_rstb = 1'b1; m_rlast = (b == 1); m_rdata = 32'h1000 + 32'(b);
            #1;
            checks++; if ({s_rstb, s_rlast, s_rdata} !== {2'b01, (b == 1) ? 2'b01 : 2'b00, 32'h1000 + 32'(b)}) begin errors++; $display("FAIL ct_p0_beat%0d got rstb=%b rlast=%b rd=%h", b, s_rstb, s_rlast, s_rdata); end
            step();
        end
        m_rstb = 1'b0; m_rlast = 1'b0;
        #1;
        checks++; if ({grant, busy} !== 3'b000) begin errors++; $display("FAIL ct_gap got g=%b busy=%b exp 00 0", grant, busy); end
        step();
        checks++; if ({grant, m_addr, m_len} !== {2'b10, 32'h300, 7'd2}) begin errors++; $display("FAIL ct_second got g=%b a=%h l=%0d exp 10 300 2", grant, m_addr, m_len); end
        m_ready = 1'b1; step();
        m_ready = 1'b0; s_valid = 2'b00;
        for (int b = 0; b < 3; b++) begin
            m_rstb = 1'b1; m_rlast = (b == 2);
            #1;
            checks++; if ({s_rstb, s_rlast} !== {2'b10, (b == 2) ? 2'b10 : 2'b00}) begin errors++; $display("FAIL ct_p1_beat%0d got rstb=%b rlast=%b", b, s_rstb, s_rlast); end
            step();
        end
        clear_inputs();
        $display("test_contention done");
    endtask

    task automatic test_fairness();
        logic [N-1:0] g0, g1, g2;
        logic [3*N-1:0] exp_order;
`ifdef MI_ARB_FIXED_PRIO_EN
        exp_order = {2'b01, 2'b01, 2'b01};
`else
        exp_order = {2'b01, 2'b10, 2'b01};
`endif
        s_rw = 2'b00; s_len = '0; s_valid = 2'b11;
        do_txn(g0);
        do_txn(g1);
        do_txn(g2);
        checks++; if ({g0, g1, g2} !== exp_order) begin errors++; $display("FAIL fair_order got %b %b %b exp %b", g0, g1, g2, exp_order); end
        clear_inputs();
        step();
        $display("test_fairness done");
    endtask

    task automatic test_abort();
        logic [N-1:0] exp_g;
`ifdef MI_ARB_FIXED_PRIO_EN
        exp_g = 2'b01;
`else
        exp_g = 2'b10;
`endif
        s_addr = {32'h500, 32'h0}; s_valid = 2'b10;
        step();
        checks++; if ({grant, m_valid} !== 3'b101) begin errors++; $display("FAIL ab_cmd got g=%b v=%b exp 10 1", grant, m_valid); end
        s_valid = 2'b00;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ab_mvalid_drop got %b exp 0", m_valid); end
        step();
        checks++; if ({grant, busy, s_wack, s_rstb} !== 7'b0) begin errors++; $display("FAIL ab_idle got g=%b busy=%b wack=%b rstb=%b exp 0", grant, busy, s_wack, s_rstb); end
        s_valid = 2'b11;
        step();
        checks++; if (grant !== exp_g) begin errors++; $display("FAIL ab_ptr_kept got %b exp %b", grant, exp_g); end
        s_valid = 2'b00;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_second got busy=%b exp 0", busy); end
        clear_inputs();
        $display("test_abort done");
    endtask

    task automatic test_stray();
        m_rstb = 1'b1; m_rlast = 1'b1; m_wack = 1'b1; m_wlast = 1'b1;
        #1;
        checks++; if ({s_rstb, s_rlast, s_wack, s_wlast} !== 8'b0) begin errors++; $display("FAIL stray_idle got rstb=%b rlast=%b wack=%b wlast=%b exp 0", s_rstb, s_rlast, s_wack, s_wlast); end
        s_valid = 2'b01;
        step();
        checks++; if ({busy, s_rstb, s_rlast, s_wack, s_wlast} !== 9'b1_00000000) begin errors++; $display("FAIL stray_cmd got busy=%b rstb=%b rlast=%b wack=%b wlast=%b exp 1 0", busy, s_rstb, s_rlast, s_wack, s_wlast); end
        clear_inputs();
        step();
        $display("test_stray done");
    endtask

    task automatic test_reset_mid();
        s_addr = {32'h400, 32'h600}; s_len = {7'd0, 7'd7}; s_rw = 2'b01; s_valid = 2'b01;
        step();
        m_ready = 1'b1; step();
        m_ready = 1'b0; s_valid = 2'b00;
        m_rstb = 1'b1; step();
        #1;
        checks++; if (s_rstb !== 2'b01) begin errors++; $display("FAIL rm_beat2 got %b exp 01", s_rstb); end
        rst_n = 1'b0;
        #1;
        checks++; if ({grant, busy, s_rstb, s_rlast, m_valid, s_ready} !== 10'b0) begin errors++; $display("FAIL rm_async got g=%b busy=%b rstb=%b rlast=%b v=%b rdy=%b exp 0", grant, busy, s_rstb, s_rlast, m_valid, s_ready); end
        m_rstb = 1'b0;
        #2;
        rst_n = 1'b1;
        s_rw = 2'b00; s_valid = 2'b10;
        step();
        checks++; if ({grant, m_valid, m_addr} !== {2'b10, 1'b1, 32'h400}) begin errors++; $display("FAIL rm_regrant got g=%b v=%b a=%h exp 10 1 400", grant, m_valid, m_addr); end
        m_ready = 1'b1; step();
        m_ready = 1'b0; s_valid = 2'b00;
        m_wack = 1'b1; m_wlast = 1'b1;
        #1;
        checks++; if ({s_wack, s_wlast} !== 4'b1010) begin errors++; $display("FAIL rm_write got wack=%b wlast=%b exp 10 10", s_wack, s_wlast); end
        step();
        clear_inputs();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_end got busy=%b exp 0", busy); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_fairness();
        test_abort();
        test_stray();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
